// File: rtl/bo_datapath.sv
// Operative datapath for the bc controller: RX/RS/RH registers, add/multiply ALU,
// operand and write-back muxes, result register with valid strobe. Option: BO_SATURATE_EN.
module bo_datapath #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [WIDTH-1:0] c_in,
   input  logic             LX,
   input  logic [1:0]       M0,
   input  logic [1:0]       M1,
   input  logic [1:0]       M2,
   input  logic             H,
   input  logic             LS,
   input  logic             LH,
   input  logic             done,
   output logic [WIDTH-1:0] result_out,
   output logic             result_valid,
   output logic             ovf,
   output logic             proto_err
);

   logic [WIDTH-1:0]   rx_q, rs_q, rh_q, result_q;
   logic [WIDTH-1:0]   rx_d, rs_d, rh_d, result_d;
   logic               valid_q, ovf_q, perr_q;
   logic               valid_d, ovf_d, perr_d;
   logic [WIDTH-1:0]   p_op, q_op, wb;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod, alu_full;
   logic               alu_ovf, ovf_set;

   always_comb begin
      p_op = a_in;
      case (M0)
         2'd0: p_op = a_in;
         2'd1: p_op = b_in;
         2'd2: p_op = c_in;
         2'd3: p_op = rs_q;
         default: p_op = a_in;
      endcase
      q_op = rx_q;
      case (M1)
         2'd0: q_op = rx_q;
         2'd1: q_op = rh_q;
         2'd2: q_op = rs_q;
         2'd3: q_op = {{(WIDTH-1){1'b0}}, 1'b1};
         default: q_op = rx_q;
      endcase
   end

   // Full-precision results; any set bit above WIDTH is a discarded (overflowing) bit.
   always_comb begin
      sum      = {1'b0, p_op} + {1'b0, q_op};
      prod     = {{WIDTH{1'b0}}, p_op} * {{WIDTH{1'b0}}, q_op};
      alu_full = H ? prod : {{(WIDTH-1){1'b0}}, sum};
      alu_ovf  = |alu_full[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      wb = '0;
      case (M2)
`ifdef BO_SATURATE_EN
         2'd0: wb = alu_ovf ? '1 : alu_full[WIDTH-1:0];
`else
         2'd0: wb = alu_full[WIDTH-1:0];
`endif
         2'd1: wb = p_op;
         2'd2: wb = q_op;
         2'd3: wb = '0;
         default: wb = '0;
      endcase
   end

   always_comb begin
      ovf_set  = (M2 == 2'd0) && (LS || LH) && alu_ovf;
      rx_d     = LX ? x_in : rx_q;
      rs_d     = LS ? wb : rs_q;
      rh_d     = LH ? wb : rh_q;
      result_d = done ? rs_q : result_q;
      valid_d  = done;
      ovf_d    = LX ? 1'b0 : (ovf_q || ovf_set);
      perr_d   = perr_q || (LS && LH);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_q     <= '0;
         rs_q     <= '0;
         rh_q     <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         rx_q     <= rx_d;
         rs_q     <= rs_d;
         rh_q     <= rh_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         perr_q   <= perr_d;
      end
   end

   assign result_out   = result_q;
   assign result_valid = valid_q;
   assign ovf          = ovf_q;
   assign proto_err    = perr_q;

endmodule

// File: tb/tb_bo_datapath.sv
// Directed bench for bo_datapath; internal registers are observed through done/result_out.
module tb_bo_datapath;

   localparam int unsigned W = 8;

   logic         clock = 1'b0;
   logic         reset;
   logic [W-1:0] x_in, a_in, b_in, c_in;
   logic         LX, H, LS, LH, done;
   logic [1:0]   M0, M1, M2;
   logic [W-1:0] result_out;
   logic         result_valid, ovf, proto_err;

   int unsigned passed = 0;
   int unsigned total  = 0;

   bo_datapath #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .x_in(x_in), .a_in(a_in), .b_in(b_in), .c_in(c_in),
      .LX(LX), .M0(M0), .M1(M1), .M2(M2), .H(H), .LS(LS), .LH(LH), .done(done),
      .result_out(result_out), .result_valid(result_valid), .ovf(ovf), .proto_err(proto_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Apply one control word for one clock, then sample 1 time unit after the edge.
   task automatic cyc(input logic lx, input logic [1:0] m0, input logic [1:0] m1,
                      input logic [1:0] m2, input logic h, input logic ls,
                      input logic lh, input logic dn);
      LX = lx; M0 = m0; M1 = m1; M2 = m2; H = h; LS = ls; LH = lh; done = dn;
      @(posedge clock); #1;
      LX = 0; LS = 0; LH = 0; done = 0; H = 0; M0 = 0; M1 = 0; M2 = 0;
   endtask

   task automatic read_rs(input string tag, input logic [W-1:0] exp);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      chk(tag, result_out, exp);
      chk({tag, "_vld"}, {7'd0, result_valid}, 8'd1);
   endtask

   initial begin
      reset = 0; x_in = 0; a_in = 0; b_in = 0; c_in = 0;
      LX = 0; M0 = 0; M1 = 0; M2 = 0; H = 0; LS = 0; LH = 0; done = 0;
      #12;
      chk("rst_result", result_out, 0);
      chk("rst_valid", {7'd0, result_valid}, 0);
      chk("rst_ovf", {7'd0, ovf}, 0);
      chk("rst_perr", {7'd0, proto_err}, 0);
      reset = 1;
      @(posedge clock); #1;

      // Test 1: RS=20, RH=7, publish 20, then async reset mid-cycle while done is high
      x_in = 20; cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 2, 0, 1, 0, 0);
      a_in = 7; cyc(0, 0, 0, 1, 0, 0, 1, 0);
      read_rs("t1_rs20", 20);
      LS = 1; done = 1;
      #3 reset = 0; #1;
      chk("t1_async_result", result_out, 0);
      chk("t1_async_valid", {7'd0, result_valid}, 0);
      @(posedge clock); #1;
      chk("t1_held_valid", {7'd0, result_valid}, 0);
      LS = 0; done = 0; reset = 1;
      @(posedge clock); #1;
      chk("t1_no_strobe", {7'd0, result_valid}, 0);
      read_rs("t1_rs0", 0);
      cyc(0, 0, 0, 2, 0, 1, 0, 0);
      read_rs("t1_rx0", 0);
      cyc(0, 0, 1, 2, 0, 1, 0, 0);
      read_rs("t1_rh0", 0);

      // Test 2: 3 * 5
      x_in = 5; cyc(1, 0, 0, 0, 0, 0, 0, 0);
      a_in = 3; cyc(0, 0, 0, 0, 1, 1, 0, 0);
      chk("t2_ovf", {7'd0, ovf}, 0);
      read_rs("t2_rs15", 15);

      // Test 3: RS + RX, single strobe then stable result, then a 2-cycle done
      cyc(0, 3, 0, 0, 0, 1, 0, 0);
      read_rs("t3_rs20", 20);
      @(posedge clock); #1;
      chk("t3_vld_low", {7'd0, result_valid}, 0);
      chk("t3_stable", result_out, 20);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      chk("t3_hold1", {7'd0, result_valid}, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      chk("t3_hold2", {7'd0, result_valid}, 1);
      @(posedge clock); #1;
      chk("t3_hold_end", {7'd0, result_valid}, 0);

      // Constant-1 Q operand and zero write-back
      a_in = 7; cyc(0, 0, 3, 0, 0, 1, 0, 0);
      read_rs("c1_rs8", 8);
      cyc(0, 0, 0, 3, 0, 1, 0, 0);
      read_rs("zero_rs", 0);

      // Test 4: 200 * 2 overflows
      x_in = 2; cyc(1, 0, 0, 0, 0, 0, 0, 0);
      a_in = 200; cyc(0, 0, 0, 0, 1, 1, 0, 0);
      chk("t4_ovf_set", {7'd0, ovf}, 1);
`ifdef BO_SATURATE_EN
      read_rs("t4_rs", 255);
`else
      read_rs("t4_rs", 144);
`endif
      // LX beats a same-cycle overflow set; ALU still sees old RX=2
      x_in = 5; cyc(1, 0, 0, 0, 1, 1, 0, 0);
      chk("t4_lx_clear", {7'd0, ovf}, 0);
      // Overflowing ALU without a load, or with non-ALU write-back, does not flag
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      chk("t4_noload", {7'd0, ovf}, 0);
      cyc(0, 0, 0, 1, 1, 1, 0, 0);
      chk("t4_m2p", {7'd0, ovf}, 0);
      // 200 + 200 sum overflow via LH only
      cyc(0, 0, 3, 1, 0, 0, 1, 0);
      cyc(0, 0, 1, 0, 0, 0, 1, 0);
      chk("t4_sum_ovf", {7'd0, ovf}, 1);

      // Test 5: LX with LS of RX uses old RX
      x_in = 9; cyc(1, 0, 0, 2, 0, 1, 0, 0);
      read_rs("t5_oldrx", 5);
      cyc(0, 0, 0, 2, 0, 1, 0, 0);
      read_rs("t5_newrx", 9);

      // Test 6: LS and LH together
      chk("t6_perr0", {7'd0, proto_err}, 0);
      b_in = 6; cyc(0, 1, 0, 1, 0, 1, 1, 0);
      chk("t6_perr1", {7'd0, proto_err}, 1);
      read_rs("t6_rs6", 6);
      cyc(0, 0, 1, 2, 0, 1, 0, 0);
      read_rs("t6_rh6", 6);
      x_in = 1; cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("t6_perr_sticky", {7'd0, proto_err}, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
